// File: rtl/phase_shift_processor.sv
// Per-PLL dynamic phase-shift sequencer: on a request addressed to this PLL it
// issues exactly N phasestep pulses, pacing each one on the PLL phasedone handshake.
module phase_shift_processor #(
  parameter int PLL_ID          = 0,
  parameter int MIN_STEP_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_periods_to_process,
  input  logic       i_phasedone,
  input  logic       i_ready,
  input  logic       i_pll_to_update,
  output logic       o_phasestep,
  output logic [2:0] o_current_state
);

  localparam int            HW        = (MIN_STEP_CYCLES > 1) ? $clog2(MIN_STEP_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MIN_STEP_CYCLES - 1);
  localparam logic          PLL_SEL   = PLL_ID[0];

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    STEP      = 3'd2,
    WAIT_LOW  = 3'd3,
    WAIT_HIGH = 3'd4,
    DONE      = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          ready_q;
  logic          step_q, step_d;
  logic          start;

  // Only a fresh rising edge seen while idle starts a run; nothing is queued.
  assign start = (state_q == IDLE) && i_ready && !ready_q && (i_pll_to_update == PLL_SEL);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      ready_q <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      ready_q <= i_ready;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = '0;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        cnt_d   = i_periods_to_process;
        state_d = (i_periods_to_process == 8'd0) ? DONE : STEP;
      end
      STEP: begin
        if (hold_q == HOLD_LAST) state_d = WAIT_LOW;
        else                     hold_d  = hold_q + HW'(1);
      end
      WAIT_LOW: if (!i_phasedone) state_d = WAIT_HIGH;
      WAIT_HIGH: begin
        if (i_phasedone) begin
          cnt_d   = cnt_q - 8'd1;
          state_d = (cnt_q == 8'd1) ? DONE : STEP;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // phasestep is registered off the next state so it tracks STEP/WAIT_LOW exactly.
  always_comb begin
    step_d = (state_d == STEP) || (state_d == WAIT_LOW);
  end

  assign o_phasestep     = step_q;
  assign o_current_state = state_q;

endmodule

// File: tb/tb_phase_shift_processor.sv
// Bench for phase_shift_processor: two instances (PLL 0 and 1) on shared inputs,
// a small PLL phasedone model and a pulse-count scoreboard on the PLL 0 instance.
module tb_phase_shift_processor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] periods;
  logic       phasedone;
  logic       ready;
  logic       pll_sel;
  logic       ps0, ps1;
  logic [2:0] st0, st1;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  phase_shift_processor #(.PLL_ID(0), .MIN_STEP_CYCLES(2)) u_pll0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_periods_to_process(periods),
    .i_phasedone(phasedone), .i_ready(ready), .i_pll_to_update(pll_sel),
    .o_phasestep(ps0), .o_current_state(st0)
  );

  phase_shift_processor #(.PLL_ID(1), .MIN_STEP_CYCLES(2)) u_pll1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_periods_to_process(periods),
    .i_phasedone(phasedone), .i_ready(ready), .i_pll_to_update(pll_sel),
    .o_phasestep(ps1), .o_current_state(st1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // PLL model: phasedone falls one cycle after a phasestep rise, rises two cycles later.
  initial begin
    int  m = 0;
    logic prev = 1'b0;
    phasedone = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        m = 0; phasedone = 1'b1;
      end else begin
        case (m)
          0: if ((ps0 | ps1) && !prev) m = 1;
          1: begin phasedone = 1'b0; m = 2; end
          2: m = 3;
          default: begin phasedone = 1'b1; m = 0; end
        endcase
      end
      prev = ps0 | ps1;
    end
  end

  // Monitor: counts PLL 0 pulses per run and scores them when the run reaches DONE.
  int   mon_pulses = 0;
  int   mon_width  = 0;
  int   mon_minw   = 1000;
  logic mon_prev   = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_pulses = 0; mon_width = 0; mon_minw = 1000; mon_prev = 1'b0;
    end else begin
      if (ps0 && !mon_prev) mon_pulses++;
      if (ps0) mon_width++;
      else if (mon_prev) begin
        if (mon_width < mon_minw) mon_minw = mon_width;
        mon_width = 0;
      end
      mon_prev = ps0;
      if (st0 == 3'd5) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          int e;
          e = exp_q.pop_front();
          chk("pulse_count", mon_pulses, e);
          if (e > 0) chk("pulse_width_ge2", int'(mon_minw >= 2), 1);
        end
        mon_pulses = 0; mon_minw = 1000;
      end
    end
  end

  task automatic do_req(input logic sel, input logic [7:0] n);
    @(negedge clk);
    pll_sel = sel; periods = n; ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  // Waits for both instances to return to idle; reports PLL 1 pulses and peak state.
  task automatic run_wait(output int p1, output int max1);
    logic prev1 = 1'b0;
    bit   seen  = 1'b0;
    p1 = 0; max1 = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (ps1 && !prev1) p1++;
      prev1 = ps1;
      if (int'(st1) > max1) max1 = int'(st1);
      if (st0 != 3'd0 || st1 != 3'd0) seen = 1'b1;
      else if (seen) return;
    end
    chk("run_timeout", 1, 0);
  endtask

  initial begin
    int p1, max1, n3;
    logic [2:0] prev_st;
    rst_n = 1'b0; ready = 1'b0; pll_sel = 1'b0; periods = 8'd0;

    // Reset held with ready toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ready = ~ready; pll_sel = 1'b0; periods = 8'd3;
      #1;
      chk("rst_phasestep", int'(ps0), 0);
      chk("rst_state", int'(st0), 0);
    end
    @(negedge clk);
    ready = 1'b0; rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_idle", int'(st0), 0);
    end

    // Three steps on PLL 0
    exp_q.push_back(3);
    do_req(1'b0, 8'd3);
    run_wait(p1, max1);

    // Request for PLL 0 while checking PLL 1 stays quiet
    exp_q.push_back(5);
    do_req(1'b0, 8'd5);
    run_wait(p1, max1);
    chk("pll1_no_pulses", p1, 0);
    chk("pll1_state_idle", max1, 0);

    // Zero periods: LOAD -> DONE -> IDLE
    exp_q.push_back(0);
    @(negedge clk);
    pll_sel = 1'b0; periods = 8'd0; ready = 1'b1;
    @(negedge clk); chk("zero_load", int'(st0), 1);
    ready = 1'b0;
    @(negedge clk); chk("zero_done", int'(st0), 5);
    @(negedge clk); chk("zero_idle", int'(st0), 0);
    chk("zero_no_step", int'(ps0), 0);

    // Four steps with repeated requests and a changed period count mid-run
    exp_q.push_back(4);
    do_req(1'b0, 8'd4);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ready = ~ready; periods = 8'd9;
    end
    @(negedge clk);
    ready = 1'b0;
    run_wait(p1, max1);

    // Reset during WAIT_LOW of step 2 of 6: no DONE expected for this run
    do_req(1'b0, 8'd6);
    n3 = 0; prev_st = 3'd0;
    for (int c = 0; c < 200 && n3 < 2; c++) begin
      @(negedge clk);
      if (st0 == 3'd3 && prev_st != 3'd3) n3++;
      prev_st = st0;
    end
    chk("reached_step2_wait_low", n3, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_phasestep", int'(ps0), 0);
    chk("abort_state", int'(st0), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(2);
    do_req(1'b0, 8'd2);
    run_wait(p1, max1);

    // PLL 1 responds to its own request; PLL 0 must not reach DONE
    do_req(1'b1, 8'd2);
    run_wait(p1, max1);
    chk("pll1_pulses", p1, 2);
    chk("pll1_reached_done", max1, 5);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/phase_shift_processor.md
Name: phase_shift_processor

Overview:
Per-PLL sequencer that drives the dynamic phase-shift handshake (phasestep/phasedone) of one PLL. Instances sit between uart_data_mapper and a PLL (pll_0_3 or pll_4_7). On a shift request addressed to its own PLL, the block issues exactly N phase steps, where N comes from the mapper. It exposes its FSM state for debug.

Parameters:
PLL_ID, 0, index of the PLL this instance serves; the block acts only when i_pll_to_update == PLL_ID[0].
MIN_STEP_CYCLES, 2, minimum number of i_clk cycles o_phasestep stays high per step (PLL requirement).

Ports:
i_clk  in  1  system clock; also the PLL scanclk.
i_rst_n  in  1  asynchronous active-low reset.
i_periods_to_process  in  8  number of phase steps to perform, unsigned binary (0..255).
i_phasedone  in  1  PLL phasedone; low while a step is in progress, high when idle/done. Same clock domain, no synchroniser.
i_ready  in  1  shift-request strobe/level from the mapper.
i_pll_to_update  in  1  target PLL select from the mapper.
o_phasestep  out  1  PLL phasestep request.
o_current_state  out  3  encoded FSM state (debug).

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, o_phasestep=0, step counter=0, hold counter=0, ready edge register=0. o_current_state=0.
- State encoding: IDLE=0, LOAD=1, STEP=2, WAIT_LOW=3, WAIT_HIGH=4, DONE=5. Codes 6 and 7 are unused and return to IDLE on the next clock.
- Start condition: rising edge of i_ready (registered compare: i_ready=1 and previous i_ready=0) while in IDLE and i_pll_to_update==PLL_ID. Rising edges outside IDLE or for the other PLL are ignored and are not queued.
- IDLE -> LOAD on start. LOAD captures i_periods_to_process into the step counter.
  - If the captured value is 0: LOAD -> DONE, no step is issued.
  - Otherwise: LOAD -> STEP.
- STEP: o_phasestep=1. The hold counter counts MIN_STEP_CYCLES cycles, then STEP -> WAIT_LOW.
- WAIT_LOW: o_phasestep stays 1 until i_phasedone is sampled 0, then -> WAIT_HIGH with o_phasestep=0 on that transition. If i_phasedone is already 0 on entry, the exit happens on the first cycle.
- WAIT_HIGH: o_phasestep=0. When i_phasedone is sampled 1, the step counter decrements.
  - New value 0: -> DONE.
  - Otherwise: -> STEP.
- DONE: lasts one cycle, -> IDLE.
- o_phasestep is registered and is high only in STEP and WAIT_LOW.
- Number of o_phasestep rising edges per request equals the captured count exactly; later changes on i_periods_to_process during operation have no effect.
- No timeout: if i_phasedone never toggles, the FSM waits indefinitely; only reset recovers it.
- Reset mid-operation: immediate return to IDLE, o_phasestep drops asynchronously, remaining steps are discarded.
- Two instances (PLL_ID 0 and 1) share i_ready and i_periods_to_process. At most one responds per request.

Test Plan:
- Reset asserted with i_ready toggling -> o_phasestep=0, o_current_state=0 throughout; after release stays IDLE until a fresh i_ready rising edge.
- PLL_ID=0, i_pll_to_update=0, periods=3, PLL model pulls i_phasedone low 1 cycle after phasestep and high 2 cycles later -> exactly 3 o_phasestep pulses, each ≥2 cycles; DONE then IDLE.
- PLL_ID=1 instance with i_pll_to_update=0, periods=5, i_ready pulse -> no o_phasestep activity, state stays 0.
- periods=0 -> states IDLE→LOAD→DONE→IDLE, zero phasestep pulses.
- i_ready pulses repeatedly and i_periods_to_process changes to 9 during a 4-step run -> exactly 4 pulses; the extra requests are ignored.
- i_rst_n pulled low during WAIT_LOW of step 2 of 6 -> o_phasestep=0 immediately, state 0; a new request for periods=2 afterward yields exactly 2 pulses.
